// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter, MSB first, one bit per clock.
// Words are taken through a valid/ready handshake. A word offered on the last
// bit of a frame is accepted there, so frames stream with no idle gap.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// after the LSB, which lengthens each frame by one bit.
module piso_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

`ifdef PISO_TX_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [FRAME-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_valid_q, sout_valid_d;
    logic             done_q, done_d;
    logic             accept;
    logic [FRAME-1:0] frame_word;

    // Frame image loaded into the shift register; its top bit goes out first.
`ifdef PISO_TX_PARITY_EN
    assign frame_word = {load_data, ^load_data};
`else
    assign frame_word = load_data;
`endif

    // Ready while idle, or on the last bit so that the next word follows without a gap.
    assign load_ready = (state_q == IDLE) || (cnt_q == '0);
    assign accept     = load_valid && load_ready;

    // Next-state logic: a load takes priority, otherwise shift or finish the frame.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sout_valid_d = 1'b0;
        done_d       = 1'b0;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = frame_word;
            cnt_d   = CW'(FRAME - 1);
        end else if (state_q == SHIFT) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
                shreg_d = '0;
            end else begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CW'(1);
            end
        end
        sout_valid_d = (state_d == SHIFT);
        done_d       = (state_d == SHIFT) && (cnt_d == '0);
    end

    // State, data path and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    // Serial bit is the top of the shift register, which clears when idle.
    assign sout       = shreg_q[FRAME-1];
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter for the sequential-logic library. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first on a single serial line, one bit per clock. A DFF-based serial receiver samples that line on the following rising edge. Back-to-back words stream with no idle gap between frames.

## Interface
- WIDTH, 8: data word width in bits; legal range 2 to 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  the block accepts a word this cycle.
- load_data  input  WIDTH  word to transmit.
- sout  output  1  serial data, registered.
- sout_valid  output  1  sout carries a frame bit this cycle, registered.
- done  output  1  one-cycle pulse on the last bit of a frame, registered.

## Operation
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; shift register and bit counter clear.
  - sout=0, sout_valid=0, done=0.
  - load_ready=1 once reset deasserts. load_ready is combinational from state.
- A word is accepted on a rising edge where load_valid=1 and load_ready=1. load_data is captured into the shift register and the bit counter loads FRAME-1.
  - FRAME = WIDTH, or WIDTH+1 when parity is compiled in.
  - The counter is $clog2(WIDTH+1) bits wide and unsigned.
- FSM states:
  - IDLE: sout_valid=0 and sout=0; load_ready=1. An accepted word moves to SHIFT.
  - SHIFT: sout_valid=1. Each edge shifts the register left by one and decrements the counter.
  - load_ready=1 only when the counter equals 0, which is the last bit.
  - At counter 0: an accepted word reloads and SHIFT continues, giving a seamless frame. With no word accepted, the FSM returns to IDLE.
- done=1 exactly in the cycle where sout carries the last bit of a frame.
- load_data and load_valid are ignored while load_ready=0. The word in flight is never corrupted.
- An asynchronous reset mid-frame aborts the frame immediately. There is no partial frame and no done pulse.

## Timing
- Latency: the word is accepted at edge N. The MSB appears on sout, with sout_valid=1, in cycle N+1 (after edge N). Bit k (MSB=0) appears in cycle N+1+k.
- The last data bit appears in cycle N+WIDTH. With parity compiled in, the parity bit appears in cycle N+WIDTH+1.
- Back-to-back: if the next word is accepted at the last-bit edge, its MSB follows in the very next cycle and sout_valid stays high.
- Throughput: 1 bit/clock; one word every FRAME cycles.
- All outputs except load_ready are registered, so sout changes only on rising edges.

## Configuration
- PISO_TX_PARITY_EN defined:
  - An even-parity bit (XOR of all WIDTH data bits) is appended after the LSB.
  - FRAME = WIDTH+1; done pulses on the parity bit.
- PISO_TX_PARITY_EN undefined:
  - No parity bit; FRAME = WIDTH; done pulses on the LSB.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, then release with load_valid=0. Required: sout=0, sout_valid=0, done=0, load_ready=1 for 10 cycles.
- Single word, WIDTH=8, no parity: accept 0xA5 at edge N. Required: sout=1,0,1,0,0,1,0,1 in cycles N+1..N+8; sout_valid=1 throughout; done=1 only in cycle N+8; IDLE in cycle N+9.
- Back-to-back: accept 0xF0, hold load_valid=1 with 0x0F ready. Required: load_ready=0 in cycles N+1..N+7 and 1 in cycle N+8. Then 16 contiguous bits 1111000000001111 with sout_valid never dropping, and two done pulses at N+8 and N+16.
- Ignored load: during a frame of 0x3C, pulse load_valid=1 with 0xFF in cycle N+3. Required: the serial output is still exactly 00111100 and 0xFF is not transmitted.
- Mid-frame reset: assert rst_n=0 in cycle N+4 of a 0xA5 frame. Required: sout=0 and sout_valid=0 immediately, with no done pulse. After release, a new word 0x81 transmits correctly.
- With PISO_TX_PARITY_EN defined, accept 0x07. Required: bits 00000111 then parity bit 1 in cycle N+9; done only in cycle N+9. Repeat with 0x03: parity bit 0.
